// File: rtl/count_trace_pkg.sv
// Shared definitions for the mod-M counter trace buffer.
// Holds the default counter/trace geometry used by both the design and the
// counter bench, the packed trace record layout for those defaults, and a
// helper that computes the record width for any parameterisation.
package count_trace_pkg;

  localparam int unsigned DEF_M     = 12;
  localparam int unsigned DEF_N     = 4;
  localparam int unsigned DEF_TW    = 16;
  localparam int unsigned DEF_DEPTH = 8;
  localparam int unsigned DEF_AW    = 3;

  // Field order matches the packed layout stored in the FIFO:
  // {timestamp, count, expected, error}, timestamp in the MSBs.
  typedef struct packed {
    logic [DEF_TW-1:0] timestamp;
    logic [DEF_N-1:0]  count;
    logic [DEF_N-1:0]  expected;
    logic              error;
  } trace_rec_t;

  localparam int unsigned REC_W = $bits(trace_rec_t);

  function automatic int unsigned rec_width(input int unsigned tw, input int unsigned n);
    return tw + 2 * n + 1;
  endfunction

endpackage

// File: rtl/count_trace_buffer_sync_fifo.sv
// Single-clock FIFO for trace records.
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   i_clr           - synchronous flush (priority over push/pop)
//   i_push, i_data  - write request and record
//   i_pop           - read request; ignored when empty
//   o_data          - head record, all-zero while empty
//   o_full/o_empty  - occupancy flags
//   o_level         - occupancy 0..DEPTH
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned W     = 25,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  input  logic          i_push,
  input  logic [W-1:0]  i_data,
  input  logic          i_pop,
  output logic [W-1:0]  o_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_level
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;

  logic w_do_push;
  logic w_do_pop;

  assign o_empty   = (r_level == '0);
  assign o_full    = (r_level == (AW+1)'(DEPTH));
  assign o_level   = r_level;
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Full + pop + push: the slot being written is the one just read, so the
  // write and the read pointer advance in the same edge keep order intact.
  assign o_data = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push && !i_clr) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_level <= r_level + 1'b1;
      else if (!w_do_push && w_do_pop) r_level <= r_level - 1'b1;
    end
  end

endmodule

// File: rtl/count_trace_buffer.sv
// Trace monitor for a mod-M counter.
// Checks the upstream count/complete_tick stream against a resyncing mod-M
// reference and queues timestamped records {time, count, expected, error}
// for a valid/ready consumer.
// Ports:
//   clk, reset        - clock, asynchronous active-low reset
//   en                - upstream counter running; check/record only when 1
//   clr               - synchronous clear of checker, timestamp, FIFO, status
//   log_all           - 1: record every en cycle; 0: only tick or error cycles
//   count_in, tick_in - observed counter outputs
//   out_valid/ready   - record handshake
//   out_time/count/expected/error - head record fields
//   overflow          - sticky: a record was dropped on a full FIFO
//   level             - FIFO occupancy
//   err_cnt           - saturating mismatch count
module count_trace_buffer
  import count_trace_pkg::*;
#(
  parameter int unsigned M     = DEF_M,
  parameter int unsigned N     = DEF_N,
  parameter int unsigned TW    = DEF_TW,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned AW    = DEF_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          clr,
  input  logic          log_all,
  input  logic [N-1:0]  count_in,
  input  logic          tick_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [TW-1:0] out_time,
  output logic [N-1:0]  out_count,
  output logic [N-1:0]  out_expected,
  output logic          out_error,
  output logic          overflow,
  output logic [AW:0]   level,
  output logic [7:0]    err_cnt
);

  localparam int unsigned RW = rec_width(TW, N);

  logic [TW-1:0] r_ts;
  logic [N-1:0]  r_exp;
  logic          r_overflow;
  logic [7:0]    r_err_cnt;

  logic          w_is_last;
  logic          w_mismatch;
  logic          w_active;
  logic          w_push_req;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [RW-1:0] w_rec;
  logic [RW-1:0] w_head;

  assign w_is_last  = (count_in == N'(M - 1));
  assign w_mismatch = (count_in != r_exp) || (tick_in != w_is_last);
  assign w_active   = en && !clr;
  assign w_push_req = w_active && (log_all || tick_in || w_mismatch);
  assign w_pop      = out_valid && out_ready;
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_rec      = {r_ts, count_in, r_exp, w_mismatch};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ts <= '0;
    end else if (clr) begin
      r_ts <= '0;
    end else begin
      r_ts <= r_ts + 1'b1;
    end
  end

  // Reference resyncs to the observed count, so a single glitch costs one
  // error record instead of a cascade.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_exp <= '0;
    end else if (clr) begin
      r_exp <= '0;
    end else if (en) begin
      r_exp <= w_is_last ? '0 : count_in + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err_cnt <= '0;
    end else if (clr) begin
      r_err_cnt <= '0;
    end else if (w_active && w_mismatch && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overflow <= 1'b0;
    end else if (clr) begin
      r_overflow <= 1'b0;
    end else if (w_push_req && !w_push) begin
      r_overflow <= 1'b1;
    end
  end

  sync_fifo #(
    .W     (RW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_clr   (clr),
    .i_push  (w_push),
    .i_data  (w_rec),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

  assign out_valid = !w_empty;
  assign {out_time, out_count, out_expected, out_error} = w_head;
  assign overflow  = r_overflow;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_count_trace_buffer.sv
module tb_count_trace_buffer;
  import count_trace_pkg::*;

  localparam int unsigned M     = DEF_M;
  localparam int unsigned N     = DEF_N;
  localparam int unsigned TW    = DEF_TW;
  localparam int unsigned DEPTH = DEF_DEPTH;
  localparam int unsigned AW    = DEF_AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic          clr;
  logic          log_all;
  logic [N-1:0]  count_in;
  logic          tick_in;
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] out_time;
  logic [N-1:0]  out_count;
  logic [N-1:0]  out_expected;
  logic          out_error;
  logic          overflow;
  logic [AW:0]   level;
  logic [7:0]    err_cnt;

  count_trace_buffer #(
    .M     (M),
    .N     (N),
    .TW    (TW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .clr          (clr),
    .log_all      (log_all),
    .count_in     (count_in),
    .tick_in      (tick_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_time     (out_time),
    .out_count    (out_count),
    .out_expected (out_expected),
    .out_error    (out_error),
    .overflow     (overflow),
    .level        (level),
    .err_cnt      (err_cnt)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model state and scoreboard of expected FIFO records.
  trace_rec_t  sb[$];
  int unsigned m_ts  = 0;
  logic [N-1:0] m_exp = '0;
  int unsigned m_err = 0;
  bit          m_ovf = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_ts  = 0;
    m_exp = '0;
    m_err = 0;
    m_ovf = 1'b0;
  endtask

  task automatic check_outputs();
    trace_rec_t h;
    check_eq("valid", 32'(out_valid), 32'(sb.size() != 0));
    check_eq("level", 32'(level), 32'(sb.size()));
    check_eq("overflow", 32'(overflow), 32'(m_ovf));
    check_eq("err_cnt", 32'(err_cnt), m_err);
    if (sb.size() != 0) begin
      h = sb[0];
      check_eq("head_time", 32'(out_time), 32'(h.timestamp));
      check_eq("head_count", 32'(out_count), 32'(h.count));
      check_eq("head_expected", 32'(out_expected), 32'(h.expected));
      check_eq("head_error", 32'(out_error), 32'(h.error));
    end
  endtask

  // Advance the model by the edge about to happen, using the current inputs.
  task automatic model_update();
    bit         pop;
    bit         push;
    bit         last;
    bit         mm;
    trace_rec_t rec;
    pop  = (sb.size() != 0) && out_ready;
    push = 1'b0;
    if (clr) begin
      model_reset();
    end else begin
      if (en) begin
        last = (count_in == N'(M - 1));
        mm   = (count_in != m_exp) || (tick_in != last);
        rec.timestamp = m_ts[TW-1:0];
        rec.count     = count_in;
        rec.expected  = m_exp;
        rec.error     = mm;
        push = log_all || tick_in || mm;
        if (mm && m_err < 255) m_err++;
        m_exp = last ? '0 : count_in + 1'b1;
      end
      if (pop) void'(sb.pop_front());
      if (push) begin
        if (sb.size() < DEPTH) sb.push_back(rec);
        else m_ovf = 1'b1;
      end
      m_ts = (m_ts + 1) % (1 << TW);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    clr = 1'b1; en = 1'b1; log_all = 1'b1; count_in = 4'd7; tick_in = 1'b1;
    cycle();
    clr = 1'b0; en = 1'b0; log_all = 1'b0; tick_in = 1'b0;
  endtask

  task automatic drain();
    en = 1'b0; out_ready = 1'b1;
    repeat (DEPTH + 1) cycle();
    out_ready = 1'b0;
    check_eq("drained_level", 32'(level), 32'd0);
  endtask

  task automatic run_counts(input int unsigned vals[$], input int unsigned tick_at);
    foreach (vals[i]) begin
      en = 1'b1;
      count_in = N'(vals[i]);
      tick_in = (vals[i] == tick_at);
      cycle();
    end
    en = 1'b0; tick_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned seq[$];
    reset = 1'b0; en = 1'b0; clr = 1'b0; log_all = 1'b0;
    count_in = '0; tick_in = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_level", 32'(level), 32'd0);
    check_eq("rst_overflow", 32'(overflow), 32'd0);
    check_eq("rst_err_cnt", 32'(err_cnt), 32'd0);
    check_eq("rst_time", 32'(out_time), 32'd0);
    reset = 1'b1;

    // Clean count 0..11, only the tick cycle is recorded.
    seq = '{0,1,2,3,4,5,6,7,8,9,10,11};
    run_counts(seq, 11);
    check_eq("t1_level", 32'(level), 32'd1);
    check_eq("t1_time", 32'(out_time), 32'd11);
    check_eq("t1_count", 32'(out_count), 32'd11);
    check_eq("t1_expected", 32'(out_expected), 32'd11);
    check_eq("t1_error", 32'(out_error), 32'd0);
    check_eq("t1_err_cnt", 32'(err_cnt), 32'd0);
    drain();

    // Overflow: 9 records into 8 entries.
    do_clr();
    log_all = 1'b1;
    seq = '{0,1,2,3,4,5,6,7,8};
    run_counts(seq, 99);
    check_eq("t2_level", 32'(level), 32'd8);
    check_eq("t2_overflow", 32'(overflow), 32'd1);
    check_eq("t2_head_time", 32'(out_time), 32'd0);
    check_eq("t2_head_count", 32'(out_count), 32'd0);
    drain();

    // Glitch 3 -> 5 gives one error, then resync.
    do_clr();
    seq = '{0,1,2,3,5,6};
    run_counts(seq, 99);
    check_eq("t3_level", 32'(level), 32'd1);
    check_eq("t3_count", 32'(out_count), 32'd5);
    check_eq("t3_expected", 32'(out_expected), 32'd4);
    check_eq("t3_error", 32'(out_error), 32'd1);
    check_eq("t3_err_cnt", 32'(err_cnt), 32'd1);
    drain();

    // Spurious tick at count 3.
    do_clr();
    seq = '{0,1,2,3};
    run_counts(seq, 3);
    check_eq("t4_level", 32'(level), 32'd1);
    check_eq("t4_count", 32'(out_count), 32'd3);
    check_eq("t4_expected", 32'(out_expected), 32'd3);
    check_eq("t4_error", 32'(out_error), 32'd1);
    drain();

    // Full FIFO with simultaneous pop and push.
    do_clr();
    log_all = 1'b1;
    seq = '{0,1,2,3,4,5,6,7};
    run_counts(seq, 99);
    check_eq("t5_full_level", 32'(level), 32'd8);
    out_ready = 1'b1;
    seq = '{8};
    run_counts(seq, 99);
    check_eq("t5_level", 32'(level), 32'd8);
    check_eq("t5_overflow", 32'(overflow), 32'd0);
    check_eq("t5_head_count", 32'(out_count), 32'd1);
    drain();

    // Asynchronous reset mid-drain.
    do_clr();
    log_all = 1'b1;
    seq = '{0,1,2,9,10};
    run_counts(seq, 99);
    check_eq("t6_level", 32'(level), 32'd5);
    check_eq("t6_err_cnt", 32'(err_cnt), 32'd1);
    out_ready = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    check_eq("t6_rst_valid", 32'(out_valid), 32'd0);
    check_eq("t6_rst_level", 32'(level), 32'd0);
    check_eq("t6_rst_err_cnt", 32'(err_cnt), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1; out_ready = 1'b0; log_all = 1'b0;

    // Persistent mismatch saturates err_cnt.
    out_ready = 1'b1;
    en = 1'b1; count_in = 4'd5; tick_in = 1'b0;
    repeat (260) cycle();
    check_eq("sat_err_cnt", 32'(err_cnt), 32'd255);
    en = 1'b0;
    drain();

    // Random traffic with occasional glitches and clears.
    do_clr();
    for (int i = 0; i < 300; i++) begin
      en = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 49) == 0);
      log_all = $urandom_range(0, 1);
      out_ready = ($urandom_range(0, 2) != 0);
      count_in = ($urandom_range(0, 9) == 0) ? N'($urandom_range(0, 15)) : m_exp;
      tick_in = (count_in == N'(M - 1)) ^ ($urandom_range(0, 19) == 0);
      cycle();
    end
    clr = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
